// File: rtl/rtc_defs_pkg.sv
// Shared RTC definitions: parser state encoding, ASCII constants and field limits.
// Also provides a two-digit decimal-to-binary helper.
package rtc_defs_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_H1,
      ST_H0,
      ST_C1,
      ST_M1,
      ST_M0,
      ST_C2,
      ST_S1,
      ST_S0,
      ST_EOL
   } parse_state_t;

   localparam logic [7:0] ASCII_T     = 8'h54;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_NINE  = 8'h39;

   localparam logic [6:0] HOUR_MAX = 7'd23;
   localparam logic [6:0] MIN_MAX  = 7'd59;

   // tens*10 + units, wide enough for "99"
   function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] units);
      logic [6:0] t;
      t = {3'b000, tens};
      return (t << 3) + (t << 1) + {3'b000, units};
   endfunction

endpackage

// File: rtl/ascii_digit.sv
// Combinational ASCII decimal digit decoder.
// value is only meaningful when is_digit is high.
module ascii_digit
   import rtc_defs_pkg::*;
(
   input  logic [7:0] ascii,
   output logic [3:0] value,
   output logic       is_digit
);

   // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value
   assign value    = ascii[3:0];
   assign is_digit = (ascii >= ASCII_ZERO) && (ascii <= ASCII_NINE);

endmodule

// File: rtl/time_set_parser.sv
// Parses "THH:MM:SS<CR|LF>" frames from a UART byte stream and loads the RTC time.
// rx_valid is a one-cycle strobe with no back-pressure; synced/err are one-cycle strobes.
module time_set_parser
   import rtc_defs_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000000
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic [4:0]   hour_out,
   output logic [5:0]   min_out,
   output logic [5:0]   sec_out,
   output logic         synced,
   output logic         err,
   output logic         busy,
   output parse_state_t state_dbg
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

   parse_state_t  state;
   logic [4:0]    hour_sh;
   logic [5:0]    min_sh;
   logic [5:0]    sec_sh;
   logic          range_bad;
   logic [CW-1:0] idle_cnt;

   logic [3:0]    dig_val;
   logic          is_digit;
   logic          byte_ok;
   logic [3:0]    tens_sel;
   logic [6:0]    field_val;

   ascii_digit u_ascii_digit (
      .ascii    (rx_data),
      .value    (dig_val),
      .is_digit (is_digit)
   );

   always_comb begin
      byte_ok  = 1'b0;
      tens_sel = hour_sh[3:0];
      case (state)
         ST_H1, ST_H0, ST_M1, ST_M0, ST_S1, ST_S0: byte_ok = is_digit;
         ST_C1, ST_C2: byte_ok = (rx_data == ASCII_COLON);
         ST_EOL:       byte_ok = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
         default:      byte_ok = 1'b0;
      endcase
      case (state)
         ST_M0:   tens_sel = min_sh[3:0];
         ST_S0:   tens_sel = sec_sh[3:0];
         default: tens_sel = hour_sh[3:0];
      endcase
   end

   // Full 0..99 value of the field whose units digit is arriving now
   assign field_val = bcd_to_bin(tens_sel, dig_val);

   // A shadow only holds 5/6 bits, so over-range is latched here and acted on at the terminator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         hour_sh   <= '0;
         min_sh    <= '0;
         sec_sh    <= '0;
         range_bad <= 1'b0;
         idle_cnt  <= '0;
         hour_out  <= '0;
         min_out   <= '0;
         sec_out   <= '0;
         synced    <= 1'b0;
         err       <= 1'b0;
      end else begin
         synced <= 1'b0;
         err    <= 1'b0;
         if (state == ST_IDLE) begin
            idle_cnt <= '0;
            if (rx_valid && (rx_data == ASCII_T)) begin
               state     <= ST_H1;
               range_bad <= 1'b0;
            end
         end else if (rx_valid) begin
            idle_cnt <= '0;
            if (!byte_ok) begin
               err <= 1'b1;
               if (rx_data == ASCII_T) begin
                  state     <= ST_H1;
                  range_bad <= 1'b0;
               end else begin
                  state <= ST_IDLE;
               end
            end else begin
               case (state)
                  ST_H1: begin
                     hour_sh <= {1'b0, dig_val};
                     state   <= ST_H0;
                  end
                  ST_H0: begin
                     hour_sh   <= field_val[4:0];
                     range_bad <= range_bad | (field_val > HOUR_MAX);
                     state     <= ST_C1;
                  end
                  ST_C1: state <= ST_M1;
                  ST_M1: begin
                     min_sh <= {2'b00, dig_val};
                     state  <= ST_M0;
                  end
                  ST_M0: begin
                     min_sh    <= field_val[5:0];
                     range_bad <= range_bad | (field_val > MIN_MAX);
                     state     <= ST_C2;
                  end
                  ST_C2: state <= ST_S1;
                  ST_S1: begin
                     sec_sh <= {2'b00, dig_val};
                     state  <= ST_S0;
                  end
                  ST_S0: begin
                     sec_sh    <= field_val[5:0];
                     range_bad <= range_bad | (field_val > MIN_MAX);
                     state     <= ST_EOL;
                  end
                  ST_EOL: begin
                     if (range_bad) begin
                        err <= 1'b1;
                     end else begin
                        hour_out <= hour_sh;
                        min_out  <= min_sh;
                        sec_out  <= sec_sh;
                        synced   <= 1'b1;
                     end
                     state <= ST_IDLE;
                  end
                  default: state <= ST_IDLE;
               endcase
            end
         end else if (idle_cnt == TIMEOUT_LAST) begin
            err      <= 1'b1;
            state    <= ST_IDLE;
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + CW'(1);
         end
      end
   end

   assign busy      = (state != ST_IDLE);
   assign state_dbg = state;

endmodule
